// File: rtl/demod_segment_pipe_ctrl.sv
// Splits each input word into NUM_SEG rotated segments and carries them through a
// LATENCY-stage register pipeline under either legacy start-level or valid/ready control.
module demod_segment_pipe_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SEG = 10,
  parameter int unsigned SEG_W   = 32,
  parameter int unsigned STEP    = 4,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned MODE    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_SEG*SEG_W-1:0] seg_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [CNT_W-1:0]         out_count
);

  localparam int unsigned OUT_W  = NUM_SEG * SEG_W;
  localparam int unsigned LCNT_W = $clog2(LATENCY + 1);
  localparam logic [LCNT_W-1:0] LAT_C = LCNT_W'(LATENCY);

  logic [OUT_W-1:0]   seg_comb;
  logic [OUT_W-1:0]   data_q [LATENCY];
  logic [OUT_W-1:0]   data_d [LATENCY];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LCNT_W-1:0]  lcnt_q, lcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               enable;
  logic               deliver;

  // Rotate-right by a per-segment constant: low half of the doubled word shifted right.
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    localparam int unsigned SH = (k * STEP) % DATA_W;
    logic [DATA_W-1:0] rot;
    assign rot = DATA_W'({in_data, in_data} >> SH);
    assign seg_comb[k*SEG_W +: SEG_W] = rot[SEG_W-1:0];
  end

  always_comb begin
    if (MODE == 0) begin
      out_valid = (lcnt_q == LAT_C);
      enable    = 1'b1;
      busy      = !out_valid;
      deliver   = out_valid && start;
    end else begin
      out_valid = vld_q[LATENCY-1];
      enable    = !out_valid || out_ready;
      busy      = |vld_q;
      deliver   = out_valid && out_ready;
    end
    in_ready  = enable;
    seg_out   = data_q[LATENCY-1];
    out_count = cnt_q;
  end

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    lcnt_d = lcnt_q;
    cnt_d  = deliver ? cnt_q + CNT_W'(1) : cnt_q;
    // Flush wins over any accept and freezes the data registers; only valids/counter clear.
    if (flush) begin
      vld_d  = '0;
      lcnt_d = '0;
    end else begin
      if (enable) begin
        data_d[0] = seg_comb;
        vld_d[0]  = in_valid;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          data_d[i] = data_q[i-1];
          vld_d[i]  = vld_q[i-1];
        end
      end
      if (!start) begin
        lcnt_d = '0;
      end else if (lcnt_q != LAT_C) begin
        lcnt_d = lcnt_q + LCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '{default: '0};
      vld_q  <= '0;
      lcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      lcnt_q <= lcnt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_demod_segment_pipe_ctrl.sv
// Self-checking bench: streaming, legacy and narrow-counter instances checked every
// cycle against a queue-based model, plus hand-computed directed expectations.
module tb_demod_segment_pipe_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned NSEG = 10;
  localparam int unsigned SEGW = 32;
  localparam int unsigned STP  = 4;
  localparam int unsigned LAT  = 3;
  localparam int unsigned OW   = NSEG * SEGW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic s_ir, s_ov, s_busy, l_ir, l_ov, l_busy, w_ir, w_ov, w_busy;
  logic [OW-1:0] s_seg, l_seg, w_seg;
  logic [15:0] s_cnt, l_cnt;
  logic [1:0]  w_cnt;

  always #5 clk = ~clk;

  demod_segment_pipe_ctrl #(.DATA_W(DW), .NUM_SEG(NSEG), .SEG_W(SEGW), .STEP(STP),
    .LATENCY(LAT), .MODE(1), .CNT_W(16)) u_s (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(s_ir), .seg_out(s_seg), .out_valid(s_ov),
    .out_ready(out_ready), .busy(s_busy), .out_count(s_cnt));

  demod_segment_pipe_ctrl #(.DATA_W(DW), .NUM_SEG(NSEG), .SEG_W(SEGW), .STEP(STP),
    .LATENCY(LAT), .MODE(0), .CNT_W(16)) u_l (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(l_ir), .seg_out(l_seg), .out_valid(l_ov),
    .out_ready(out_ready), .busy(l_busy), .out_count(l_cnt));

  demod_segment_pipe_ctrl #(.DATA_W(DW), .NUM_SEG(NSEG), .SEG_W(SEGW), .STEP(STP),
    .LATENCY(LAT), .MODE(1), .CNT_W(2)) u_w (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(w_ir), .seg_out(w_seg), .out_valid(w_ov),
    .out_ready(out_ready), .busy(w_busy), .out_count(w_cnt));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Segment k bit i is word bit (i + k*STEP) mod DW.
  function automatic logic [OW-1:0] segs(input logic [DW-1:0] w);
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < NSEG; k++)
      for (int i = 0; i < SEGW; i++)
        r[k*SEGW+i] = w[(i + k*STP) % DW];
    return r;
  endfunction

  // Streaming model: each accepted word ages once per advancing edge; it is at the
  // output when its age reaches LAT.
  typedef struct { logic [DW-1:0] w; int unsigned age; } ent_t;
  ent_t q[$];
  int unsigned m_cnt = 0;
  // Legacy model: run length of start-high edges since last flush/drop, input history.
  logic [DW-1:0] hist[$];
  int unsigned run = 0;
  int unsigned lm_cnt = 0;
  bit mv, men, lv;

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].age == LAT);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete(); hist.delete();
      m_cnt = 0; run = 0; lm_cnt = 0;
    end else begin
      mv  = m_valid();
      men = !mv || out_ready;
      if (mv && out_ready) m_cnt++;
      if (flush) q.delete();
      else if (men) begin
        if (mv) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (in_valid) q.push_back('{w: in_data, age: 1});
      end
      lv = (run >= LAT);
      if (lv && start) lm_cnt++;
      if (flush) run = 0;
      else begin
        hist.push_back(in_data);
        if (hist.size() > LAT + 2) void'(hist.pop_front());
        run = start ? run + 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("s_out_valid", OW'(s_ov), OW'(m_valid()));
      chk("s_in_ready", OW'(s_ir), OW'(!m_valid() || out_ready));
      chk("s_busy", OW'(s_busy), OW'(q.size() != 0));
      chk("s_out_count", OW'(s_cnt), OW'(m_cnt % 65536));
      if (m_valid()) chk("s_seg_out", s_seg, segs(q[0].w));
      chk("w_out_valid", OW'(w_ov), OW'(m_valid()));
      chk("w_out_count", OW'(w_cnt), OW'(m_cnt % 4));
      if (m_valid()) chk("w_seg_out", w_seg, segs(q[0].w));
      chk("l_out_valid", OW'(l_ov), OW'(run >= LAT));
      chk("l_busy", OW'(l_busy), OW'(run < LAT));
      chk("l_in_ready", OW'(l_ir), OW'(1));
      chk("l_out_count", OW'(l_cnt), OW'(lm_cnt % 65536));
      if (run >= LAT && hist.size() >= LAT) chk("l_seg_out", l_seg, segs(hist[hist.size()-LAT]));
    end
  end

  logic [DW-1:0] wv [5];
  int unsigned first, last, k, lat;
  logic [15:0] cnt0;
  logic [1:0] wexp [5];

  initial begin
    for (int i = 0; i < 5; i++) wv[i] = $urandom;
    wexp[0] = 2'd1; wexp[1] = 2'd2; wexp[2] = 2'd3; wexp[3] = 2'd0; wexp[4] = 2'd1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_seg", s_seg, '0);
    chk("rst_valid", OW'(s_ov), OW'(0));
    chk("rst_busy_s", OW'(s_busy), OW'(0));
    chk("rst_busy_l", OW'(l_busy), OW'(1));
    chk("rst_count", OW'(s_cnt), OW'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", OW'(s_ir), OW'(1));

    // Segment values of a single word
    @(posedge clk); #1 in_data = 32'h12345678; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      if (s_ov && lat == 0) begin
        lat = e;
        chk("seg0", OW'(s_seg[0*32 +: 32]), OW'(32'h12345678));
        chk("seg1", OW'(s_seg[1*32 +: 32]), OW'(32'h81234567));
        chk("seg2", OW'(s_seg[2*32 +: 32]), OW'(32'h78123456));
        chk("seg8", OW'(s_seg[8*32 +: 32]), OW'(32'h12345678));
        chk("seg9", OW'(s_seg[9*32 +: 32]), OW'(32'h81234567));
      end else if (lat != 0 && e == lat + 1) begin
        chk("single_count", OW'(s_cnt), OW'(1));
      end
    end
    chk("single_latency", OW'(lat), OW'(3));

    // Five back-to-back words
    cnt0 = s_cnt; first = 0; last = 0; k = 0;
    in_data = wv[0]; in_valid = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e < 5) in_data = wv[e]; else in_valid = 1'b0;
      @(negedge clk);
      if (s_ov) begin
        if (first == 0) first = e;
        last = e;
        if (k < 5) chk("stream_order", OW'(s_seg[31:0]), OW'(wv[k]));
        k++;
      end
    end
    chk("stream_first", OW'(first), OW'(3));
    chk("stream_last", OW'(last), OW'(7));
    chk("stream_n", OW'(k), OW'(5));
    chk("stream_count", OW'(s_cnt - cnt0), OW'(5));
    chk("stream_busy", OW'(s_busy), OW'(0));

    // Backpressure: 4 stall cycles with 3 words in flight
    cnt0 = s_cnt; k = 0;
    in_data = wv[0]; in_valid = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e < 3) in_data = wv[e]; else in_valid = 1'b0;
      out_ready = !(e >= 3 && e < 7);
      @(negedge clk);
      if (e >= 3 && e < 7) begin
        chk("stall_in_ready", OW'(s_ir), OW'(0));
        chk("stall_valid", OW'(s_ov), OW'(1));
        chk("stall_seg", OW'(s_seg[31:0]), OW'(wv[0]));
      end else if (s_ov) begin
        if (k < 3) chk("bp_order", OW'(s_seg[31:0]), OW'(wv[k]));
        k++;
      end
    end
    chk("bp_n", OW'(k), OW'(3));
    chk("bp_count", OW'(s_cnt - cnt0), OW'(3));

    // Legacy start held 5 cycles
    cnt0 = l_cnt;
    start = 1'b1; in_data = $urandom;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      in_data = $urandom;
      if (e == 5) start = 1'b0;
      @(negedge clk);
      if (e <= 5) begin
        chk("leg_valid", OW'(l_ov), OW'(e >= 3));
        chk("leg_busy", OW'(l_busy), OW'(e < 3));
      end else begin
        chk("leg_drop_valid", OW'(l_ov), OW'(0));
        chk("leg_drop_busy", OW'(l_busy), OW'(1));
      end
    end
    chk("leg_count", OW'(l_cnt - cnt0), OW'(2));

    // Flush with 2 words in flight plus a new word
    cnt0 = s_cnt; k = 0;
    in_data = wv[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e == 1) in_data = wv[1];
      else if (e == 2) begin in_data = wv[2]; flush = 1'b1; end
      else begin flush = 1'b0; in_valid = 1'b0; end
      @(negedge clk);
      if (e == 3) chk("flush_busy", OW'(s_busy), OW'(0));
      if (e >= 3 && s_ov) k++;
    end
    chk("flush_no_out", OW'(k), OW'(0));
    chk("flush_count", OW'(s_cnt), OW'(cnt0));

    // Asynchronous reset mid-stream
    in_data = wv[3]; in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("areset_seg", s_seg, '0);
    chk("areset_valid", OW'(s_ov), OW'(0));
    chk("areset_busy", OW'(s_busy), OW'(0));
    chk("areset_count", OW'(s_cnt), OW'(0));
    chk("areset_lbusy", OW'(l_busy), OW'(1));
    in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // Narrow counter wrap over 5 deliveries
    in_data = wv[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e < 5) in_data = wv[e]; else in_valid = 1'b0;
      @(negedge clk);
      if (e >= 4) chk("wrap_count", OW'(w_cnt), OW'(wexp[e-4]));
    end

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_data   = $urandom;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      start     = ($urandom_range(0, 19) < 17);
      flush     = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
